// File: rtl/multiplier_32bit.sv
`default_nettype none
// ============================================================================
//  Module      : multiplier_32bit
//  Description : Registered 32x32 unsigned multiplier with run-time lane
//                precision (1x32, 2x16 or 4x8 packed lanes). Built as a
//                Vedic (Urdhva-Tiryakbhyam) hierarchy:
//                2x2 -> 4x4 -> 8x8 -> 16x16 -> 32x32.
//                The result is registered, so latency is one clock.
//  Revision    : 1.0  initial release
// ============================================================================
module multiplier_32bit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] operand_a_32bit,
    input  logic [31:0] operand_b_32bit,
    input  logic [1:0]  precision,
    output logic [63:0] output_32bit_mul
);

    // Precision encodings. 2'b11 is treated as full 32-bit.
    localparam logic [1:0] C_PREC_8  = 2'b00;
    localparam logic [1:0] C_PREC_16 = 2'b01;

    // ------------------------------------------------------------------------
    // Vedic building blocks. Each level forms hi*hi, lo*lo and the two cross
    // terms. {hh, ll} is hh shifted by full width plus ll. The cross sum,
    // which is one bit wider, is added at a half-width shift.
    // ------------------------------------------------------------------------
    function automatic logic [3:0] vedic_2x2(input logic [1:0] a, input logic [1:0] b);
        logic p1_a;
        logic p1_b;
        logic carry;
        logic hh;
        p1_a  = a[1] & b[0];
        p1_b  = a[0] & b[1];
        carry = p1_a & p1_b;
        hh    = a[1] & b[1];
        return {hh & carry, hh ^ carry, p1_a ^ p1_b, a[0] & b[0]};
    endfunction

    function automatic logic [7:0] vedic_4x4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] hh;
        logic [3:0] hl;
        logic [3:0] lh;
        logic [3:0] ll;
        logic [4:0] mid;
        hh  = vedic_2x2(a[3:2], b[3:2]);
        hl  = vedic_2x2(a[3:2], b[1:0]);
        lh  = vedic_2x2(a[1:0], b[3:2]);
        ll  = vedic_2x2(a[1:0], b[1:0]);
        mid = {1'b0, hl} + {1'b0, lh};
        return {hh, ll} + {1'b0, mid, 2'b00};
    endfunction

    function automatic logic [15:0] vedic_8x8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] hh;
        logic [7:0] hl;
        logic [7:0] lh;
        logic [7:0] ll;
        logic [8:0] mid;
        hh  = vedic_4x4(a[7:4], b[7:4]);
        hl  = vedic_4x4(a[7:4], b[3:0]);
        lh  = vedic_4x4(a[3:0], b[7:4]);
        ll  = vedic_4x4(a[3:0], b[3:0]);
        mid = {1'b0, hl} + {1'b0, lh};
        return {hh, ll} + {3'b000, mid, 4'b0000};
    endfunction

    // With cross_en low the two 8x8 lane products come out packed at [31:16]
    // and [15:0] with nothing overlapping, so no carry can cross lanes.
    function automatic logic [31:0] vedic_16x16(input logic [15:0] a, input logic [15:0] b,
                                                input logic cross_en);
        logic [15:0] hh;
        logic [15:0] hl;
        logic [15:0] lh;
        logic [15:0] ll;
        logic [16:0] mid;
        hh  = vedic_8x8(a[15:8], b[15:8]);
        hl  = vedic_8x8(a[15:8], b[7:0]);
        lh  = vedic_8x8(a[7:0], b[15:8]);
        ll  = vedic_8x8(a[7:0], b[7:0]);
        mid = cross_en ? ({1'b0, hl} + {1'b0, lh}) : 17'd0;
        return {hh, ll} + {7'd0, mid, 8'd0};
    endfunction

    logic        w_cross_en_32;
    logic        w_cross_en_16;
    logic [31:0] w_hh;
    logic [31:0] w_hl;
    logic [31:0] w_lh;
    logic [31:0] w_ll;
    logic [32:0] w_mid;
    logic [63:0] w_product;
    logic [63:0] r_product;

    // Cross terms above the lane width are gated: the 32-level cross terms
    // survive only in 32-bit mode, and the 16-level cross terms in every
    // mode except 8-bit lanes.
    assign w_cross_en_32 = (precision != C_PREC_8) && (precision != C_PREC_16);
    assign w_cross_en_16 = (precision != C_PREC_8);

    // Top-level 32x32 combine; lane products land directly at packed offsets.
    always_comb begin
        w_hh      = vedic_16x16(operand_a_32bit[31:16], operand_b_32bit[31:16], w_cross_en_16);
        w_ll      = vedic_16x16(operand_a_32bit[15:0],  operand_b_32bit[15:0],  w_cross_en_16);
        w_hl      = vedic_16x16(operand_a_32bit[31:16], operand_b_32bit[15:0],  1'b1);
        w_lh      = vedic_16x16(operand_a_32bit[15:0],  operand_b_32bit[31:16], 1'b1);
        w_mid     = w_cross_en_32 ? ({1'b0, w_hl} + {1'b0, w_lh}) : 33'd0;
        w_product = {w_hh, w_ll} + {15'd0, w_mid, 16'd0};
    end

    // Output register: cleared asynchronously, otherwise loads every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_product <= 64'd0;
        end else begin
            r_product <= w_product;
        end
    end

    assign output_32bit_mul = r_product;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_32bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiplier_32bit
//  Description : Scoreboard bench for multiplier_32bit. The driver pushes the
//                expected product for every applied vector; a monitor pops
//                and compares one edge later.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multiplier_32bit;

    logic        clk;
    logic        rst;
    logic [31:0] operand_a_32bit;
    logic [31:0] operand_b_32bit;
    logic [1:0]  precision;
    logic [63:0] output_32bit_mul;

    typedef struct {
        logic [63:0] exp;
        string       tag;
    } sb_t;

    sb_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    multiplier_32bit dut (
        .clk              (clk),
        .rst              (rst),
        .operand_a_32bit  (operand_a_32bit),
        .operand_b_32bit  (operand_b_32bit),
        .precision        (precision),
        .output_32bit_mul (output_32bit_mul)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
        end
    endtask

    // Lane-wise reference product, independent of the Vedic structure.
    function automatic logic [63:0] ref_mul(input logic [1:0] p, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] r;
        r = 64'd0;
        case (p)
            2'b00: begin
                for (int i = 0; i < 4; i++)
                    r[16*i +: 16] = 16'(a[8*i +: 8]) * 16'(b[8*i +: 8]);
            end
            2'b01: r = {32'(a[31:16]) * 32'(b[31:16]), 32'(a[15:0]) * 32'(b[15:0])};
            default: r = 64'(a) * 64'(b);
        endcase
        return r;
    endfunction

    task automatic apply(input string tag, input logic [1:0] p, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
        sb_t item;
        @(negedge clk);
        precision       = p;
        operand_a_32bit = a;
        operand_b_32bit = b;
        item.exp = exp;
        item.tag = tag;
        exp_q.push_back(item);
    endtask

    // Monitor: one result per edge while anything is outstanding.
    initial begin
        sb_t item;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                item = exp_q.pop_front();
                check(item.tag, output_32bit_mul, item.exp);
            end
        end
    end

    // Driver
    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rp;

        rst             = 1'b1;
        precision       = 2'b10;
        operand_a_32bit = 32'd3;
        operand_b_32bit = 32'd5;
        @(posedge clk);
        #1;
        check("pre_reset_product", output_32bit_mul, 64'd15);

        // Load a pending operand pair, then reset before the edge that would take it.
        @(negedge clk);
        operand_a_32bit = 32'd7;
        operand_b_32bit = 32'd9;
        #2;
        rst = 1'b0;
        #1;
        check("async_clear", output_32bit_mul, 64'd0);
        @(posedge clk);
        #1;
        check("hold_in_reset", output_32bit_mul, 64'd0);
        @(posedge clk);
        #1;
        check("hold_in_reset_2", output_32bit_mul, 64'd0);

        // Release: the very next edge must present 7*9.
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back('{exp: 64'd63, tag: "first_after_reset"});

        // Directed vectors, back to back, precision changing every cycle.
        apply("m10_max",      2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        apply("m01_lanes",    2'b01, 32'hFFFF_0002, 32'hFFFF_0003, 64'hFFFE_0001_0000_0006);
        apply("m00_lanes",    2'b00, 32'hFF02_0304, 32'hFF05_0607, 64'hFE01_000A_0012_001C);
        apply("m11_max",      2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        apply("m10_decimal",  2'b10, 32'd992600595, 32'd1764109936, 64'd1751056572119011920);
        apply("m01_max",      2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFE_0001_FFFE_0001);
        apply("m00_max",      2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFE01_FE01_FE01_FE01);
        apply("m10_carry32",  2'b10, 32'h0001_8000, 32'h0001_8000, 64'h0000_0002_4000_0000);
        apply("m01_nocross",  2'b01, 32'h0001_8000, 32'h0001_8000, 64'h0000_0001_4000_0000);
        apply("m00_nocarry",  2'b00, 32'h8080_8080, 32'h0202_0202, 64'h0100_0100_0100_0100);
        apply("m10_zero",     2'b10, 32'h0000_0000, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000);
        apply("m11_decimal",  2'b11, 32'd992600595, 32'd1764109936, 64'd1751056572119011920);

        // Short randomized sweep, cycling through all four precision codes.
        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            rb = $urandom;
            rp = 2'(i % 4);
            apply($sformatf("rand_%0d_p%0d", i, rp), rp, ra, rb, ref_mul(rp, ra, rb));
        end

        // Drain the scoreboard.
        @(negedge clk);
        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
